instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch sequencer with redirect, stall and PC legality checking.
// Revision 1.0
`default_nettype none

module instruction_fetch #(
   parameter int          IMEM_BYTES   = 1024,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [31:0] next_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        pc_fault
);

   localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [31:0] target_q;
   logic [31:0] addr_nx;
   logic [31:0] seq_pc;
   logic [31:0] drain_target;
   logic        capture;
   logic        load_addr;
   logic        load_target;
   logic        set_fault;

   function automatic logic is_legal(input logic [31:0] a);
      return (a < IMEM_LIMIT) && (a[1:0] == 2'b00);
   endfunction

   always_comb begin
      state_nx     = state;
      next_pc      = pc;
      imem_req     = 1'b0;
      addr_nx      = pc;
      capture      = 1'b0;
      load_addr    = 1'b0;
      load_target  = 1'b0;
      set_fault    = 1'b0;
      seq_pc       = pc + 32'd4;
      // A redirect arriving on the draining response cycle supersedes the latched one
      drain_target = redirect_valid ? redirect_target : target_q;

      case (state)
         IDLE: begin
            if (redirect_valid) begin
               if (is_legal(redirect_target)) begin
                  next_pc = redirect_target;
               end else begin
                  set_fault = 1'b1;
                  state_nx  = FAULT;
               end
            end else if (!stall) begin
               load_addr = 1'b1;
               state_nx  = REQ;
            end
         end
         REQ: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               capture = !redirect_valid;
               addr_nx = redirect_valid ? redirect_target : seq_pc;
               if (is_legal(addr_nx)) begin
                  next_pc   = addr_nx;
                  load_addr = !stall;
                  state_nx  = stall ? IDLE : REQ;
               end else begin
                  set_fault = 1'b1;
                  state_nx  = FAULT;
               end
            end else if (redirect_valid) begin
               load_target = 1'b1;
               state_nx    = DRAIN;
            end
         end
         DRAIN: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               if (is_legal(drain_target)) begin
                  next_pc  = drain_target;
                  state_nx = IDLE;
               end else begin
                  set_fault = 1'b1;
                  state_nx  = FAULT;
               end
            end else if (redirect_valid) begin
               load_target = 1'b1;
            end
         end
         default: begin
            state_nx = FAULT;
         end
      endcase

      if (rst) begin
         next_pc  = RESET_VECTOR;
         imem_req = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         imem_addr   <= 32'd0;
         target_q    <= 32'd0;
         instr_valid <= 1'b0;
         instr       <= 32'd0;
         instr_pc    <= 32'd0;
         pc_fault    <= 1'b0;
      end else begin
         state       <= state_nx;
         instr_valid <= capture;
         if (capture) begin
            instr    <= imem_rdata;
            instr_pc <= imem_addr;
         end
         if (load_addr) begin
            imem_addr <= addr_nx;
         end
         if (load_target) begin
            target_q <= redirect_target;
         end
         if (set_fault) begin
            pc_fault <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire
